// File: rtl/prio_drain_enc.sv
// ---------------------------------------------------------------------------
// prio_drain_enc
//   Captures a request vector and reports its set bit indices one at a time,
//   in priority order, over a valid/ready handshake. Each accepted index is
//   cleared from the pending vector until it is empty.
//
// Parameters
//   WIDTH     : request vector width (power of two, 4..64)
//   MSB_FIRST : 1 = highest set index first, 0 = lowest set index first
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req_in    : request vector, sampled only on an accepted load
//   load      : capture req_in (honoured only while idle)
//   flush     : synchronous abort, discards all pending bits
//   out_ready : consumer accepts out_idx this cycle
//   out_valid : out_idx holds a pending index
//   out_idx   : index currently reported (0 when out_valid=0)
//   out_last  : reported index is the final pending bit
//   busy      : block is draining
//   none      : one-cycle pulse, the loaded vector was all zeros
// ---------------------------------------------------------------------------
module prio_drain_enc #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDXW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic             load,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             none
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t            state;
    logic [WIDTH-1:0]  pending;
    logic              none_q;
    logic [IDXW-1:0]   sel_idx;
    logic              single_bit;

    // Priority encoder over the registered pending vector only; req_in never
    // reaches the outputs combinationally.
    always_comb begin
        // NOTE: default first so every path assigns sel_idx and no latch is inferred.
        sel_idx = '0;
        if (MSB_FIRST) begin
            // Ascending scan: the last hit (highest index) wins.
            for (int i = 0; i < WIDTH; i++)
                if (pending[i]) sel_idx = IDXW'(i);
        end else begin
            // Descending scan: the last hit (lowest index) wins.
            for (int i = WIDTH - 1; i >= 0; i--)
                if (pending[i]) sel_idx = IDXW'(i);
        end
    end

    // Exactly one bit set: clearing the lowest set bit leaves zero.
    assign single_bit = (pending != '0) && ((pending & (pending - ONE)) == '0);

    // DRAIN is only ever entered with a non-zero vector and left on the
    // transfer of its final bit, so the state alone qualifies the output.
    assign out_valid = (state == DRAIN);
    assign out_idx   = out_valid ? sel_idx : '0;
    assign out_last  = out_valid & single_bit;
    assign busy      = (state == DRAIN);
    assign none      = none_q;

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: pending is real control state (it gates out_valid), so it is
            // reset; leaving it unreset would let a stale index escape after reset.
            state   <= IDLE;
            pending <= '0;
            none_q  <= 1'b0;
        end else if (flush) begin
            // Abort wins over load and over a coincident transfer.
            state   <= IDLE;
            pending <= '0;
            none_q  <= 1'b0;
        end else begin
            none_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        if (req_in != '0) begin
                            pending <= req_in;
                            state   <= DRAIN;
                        end else begin
                            none_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // load is ignored here; only a handshake modifies pending.
                    if (out_ready) begin
                        pending[sel_idx] <= 1'b0;
                        if (single_bit) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/prio_drain_enc.md
PRIO_DRAIN_ENC -- requirements
Module: prio_drain_enc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the request vector width (power of two, 4..64).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means the highest set index is reported first and 0 means the lowest set index is reported first.
REQ-003 The block SHALL have derived localparam IDXW = log2(WIDTH), giving the index width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req_in, input, WIDTH bits: the request vector, sampled only on load.
REQ-007 Port load, input, 1 bit: capture req_in; honoured only in IDLE.
REQ-008 Port flush, input, 1 bit: synchronous abort; discards all pending bits.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts out_idx.
REQ-010 Port out_valid, output, 1 bit: out_idx holds a pending index.
REQ-011 Port out_idx, output, IDXW bits: the currently reported bit index.
REQ-012 Port out_last, output, 1 bit: the reported index is the final pending bit.
REQ-013 Port busy, output, 1 bit: the block is in DRAIN.
REQ-014 Port none, output, 1 bit: a one-cycle pulse indicating that the captured vector was all zeros.

Function
REQ-015 The block SHALL hold a WIDTH-bit pending register and a two-state FSM: IDLE, DRAIN.
REQ-016 In IDLE with load=1 and req_in!=0, the block SHALL copy req_in into pending and enter DRAIN; out_valid SHALL be 1 in the next cycle (1-cycle latency).
REQ-017 In IDLE with load=1 and req_in==0, the block SHALL pulse none=1 for exactly the next cycle, remain in IDLE, and keep out_valid=0.
REQ-018 In DRAIN, out_valid SHALL be 1 and out_idx SHALL be the highest set index of pending (MSB_FIRST=1) or the lowest set index (MSB_FIRST=0); both SHALL be derived from registered state only, with no combinational path from req_in.
REQ-019 The transfer SHALL occur on a cycle where out_valid=1 and out_ready=1; the reported bit SHALL be cleared in pending at that edge.
REQ-020 out_idx and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 out_last SHALL be 1 exactly when out_valid=1 and pending has one set bit.
REQ-022 A transfer with out_last=1 SHALL return the FSM to IDLE; out_valid SHALL be 0 in the following cycle.
REQ-023 One index SHALL be transferred per cycle maximum; a vector of K set bits with out_ready held at 1 SHALL drain in exactly K cycles.
REQ-024 load in DRAIN SHALL be ignored; pending SHALL not change.
REQ-025 flush=1 in any state SHALL clear pending, enter IDLE, and force out_valid=0 next cycle; flush SHALL take priority over load and over a simultaneous transfer.
REQ-026 When out_valid=0, out_idx and out_last SHALL be driven 0.
REQ-027 busy SHALL equal (state==DRAIN).
REQ-028 A back-to-back reload SHALL work: in the cycle after the final transfer (IDLE), load SHALL be accepted normally.
REQ-029 Index WIDTH-1 and index 0 SHALL both be reportable; no index value SHALL be reserved.

Reset
REQ-030 While rst_n=0, the block SHALL immediately set state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, busy=0, and none=0.
REQ-031 Reset asserted mid-DRAIN SHALL discard all pending bits; after release, no stale index SHALL appear.
REQ-032 After release of rst_n, the first rising edge SHALL be able to accept load.

Verification
REQ-033 Default parameters, load with req_in=16'h8421 and out_ready=1 -> out_idx sequence 15, 10, 5, 0 on consecutive cycles; out_last only on 0; busy falls after the 4th transfer.
REQ-034 MSB_FIRST=0, req_in=16'h8421 -> sequence 0, 5, 10, 15.
REQ-035 load with req_in=0 -> none=1 for exactly one cycle; out_valid stays 0; busy stays 0.
REQ-036 req_in=16'h0003, out_ready=0 for 3 cycles then 1 -> out_idx=1 held stable for 3 cycles, then 1 followed by 0 (last); a load during DRAIN with 16'hFFFF has no effect.
REQ-037 req_in=16'hFFFF, flush asserted coincident with the 3rd transfer -> out_valid=0 next cycle, busy=0; a new load of 16'h0010 then yields the single index 4 with out_last=1.
REQ-038 rst_n pulsed low asynchronously mid-drain of 16'hF000 -> all outputs 0 without a clock edge; after release, out_valid stays 0 until a new load.
